mem_responder: RTL

- Memory-side responder for the load/store controller's handshake.
- Samples a request (mem_EN, mem_RW, address from MAR, write data from MDR) and performs the access on an internal word array after a fixed latency.
- Signals completion by asserting MFC (memory function complete).
- Sits between the MAR/MDR datapath registers and the controller FSM that waits on MFC.

---
 rtl/mem_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: samples a MAR/MDR request, performs the
// word access after a fixed latency and raises MFC until released.
module mem_responder #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_EN,
  input  logic              mem_RW,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              MFC,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0] LP_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_nxt;
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_mfc;
  logic                r_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_latch;
  logic                w_complete;
  logic                w_release;
  logic                w_acc_rw;
  logic [ADDR_W-1:0]   w_acc_addr;
  logic [DATA_W-1:0]   w_acc_wdata;
  logic                w_in_range;
  logic [IDX_W-1:0]    w_idx;

  // Next-state logic: sample, count down, complete, release.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_complete  = 1'b0;
    w_release   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (mem_EN) begin
          w_latch = 1'b1;
          if (LATENCY == 1) begin
            w_state_nxt = S_DONE;
            w_complete  = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_ACCESS;
            w_cnt_nxt   = LP_LOAD;
          end
        end
      end
      S_ACCESS: begin
        if (!mem_EN) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == 4'd1) begin
          w_state_nxt = S_DONE;
          w_complete  = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_DONE: begin
        if (!mem_EN) begin
          w_state_nxt = S_IDLE;
          w_release   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Single-cycle completion sees live inputs; otherwise latched ones.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_acc_rw    = mem_RW;
      w_acc_addr  = addr;
      w_acc_wdata = wdata;
    end else begin
      w_acc_rw    = r_rw;
      w_acc_addr  = r_addr;
      w_acc_wdata = r_wdata;
    end
    w_in_range = {1'b0, w_acc_addr} < LP_DEPTH;
    w_idx      = w_acc_addr[IDX_W-1:0];
  end

  // Control state, request latch and response registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mfc   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_rw    <= mem_RW;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
      if (w_complete) begin
        r_mfc <= 1'b1;
        r_err <= !w_in_range;
        if (w_acc_rw) begin
          r_rdata <= w_in_range ? r_mem[w_idx] : '0;
        end
      end else if (w_release) begin
        r_mfc <= 1'b0;
        r_err <= 1'b0;
      end
    end
  end

  // Word array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (rst && w_complete && !w_acc_rw && w_in_range) begin
      r_mem[w_idx] <= w_acc_wdata;
    end
  end

  assign rdata = r_rdata;
  assign MFC   = r_mfc;
  assign err   = r_err;
  assign busy  = (r_state != S_IDLE);

endmodule
